pic24icsp_target: RTL and testbench

Target-side emulator of the PIC24 ICSP serial programming interface. It receives the 4-bit command and 24-bit SIX instruction stream that our flash programmer drives on PGCx/PGDx, and presents each decoded instruction to a local consumer through a valid/ready handshake. On a REGOUT command it shifts a 16-bit VISI word back out on PGDx. It is used as a loopback target on the board and in the programmer's testbench in place of a real PIC24.

---
 rtl/pic24icsp_pkg.sv | 21 ++
 rtl/pic24icsp_if.sv | 22 ++
 rtl/pic24icsp_edge_sync.sv | 45 ++++
 rtl/pic24icsp_target.sv | 191 +++++++++++++++++++
 tb/tb_pic24icsp_target.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pic24icsp_pkg.sv
// Shared command codes, field widths and protocol-engine states for the
// PIC24 ICSP target emulator.
package pic24icsp_pkg;

  localparam int unsigned CMD_BITS  = 4;
  localparam int unsigned SIX_BITS  = 24;
  localparam int unsigned VISI_BITS = 16;

  localparam logic [CMD_BITS-1:0] CMD_SIX    = 4'b0000;
  localparam logic [CMD_BITS-1:0] CMD_REGOUT = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SIX_DATA,
    ST_SKIP,
    ST_REG_PAD,
    ST_REG_DATA
  } state_e;

endpackage

// File: rtl/pic24icsp_if.sv
// Consumer-side bundle: decoded SIX word with valid/ready handshake plus
// protocol status flags.
interface pic24icsp_if;
  import pic24icsp_pkg::*;

  logic [SIX_BITS-1:0] instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                overrun;
  logic                cmd_err;

  modport master (
    output instr, instr_valid, overrun, cmd_err,
    input  instr_ready
  );

  modport slave (
    input  instr, instr_valid, overrun, cmd_err,
    output instr_ready
  );

endinterface

// File: rtl/pic24icsp_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input with registered
// rise/fall pulses, each detected one cycle after the last stage changes.
module pic24icsp_edge_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pic24icsp_target.sv
// PIC24 ICSP target: decodes 4-bit commands from PGC/PGD, delivers SIX words
// over a valid/ready handshake and shifts VISI back out on REGOUT.
module pic24icsp_target
  import pic24icsp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PAD_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 PGC,
  input  logic                 PGD_in,
  output logic                 PGD_out,
  output logic                 PGD_oe,
  input  logic                 MCLRn,
  input  logic [VISI_BITS-1:0] visi,
  pic24icsp_if.master          cons
);

  localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0] SIX_LAST  = 5'(SIX_BITS - 1);
  localparam logic [4:0] VISI_LAST = 5'(VISI_BITS - 1);
  localparam logic [4:0] PAD_LAST  = 5'(PAD_BITS - 1);

  logic pgc_lvl_unused, pgc_rise, pgc_fall;
  logic pgd_lvl, pgd_rise_unused, pgd_fall_unused;
  logic mclr_lvl, mclr_rise, mclr_fall_unused;

  pic24icsp_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pgc (
    .clk(clk), .rstn(rstn), .d(PGC),
    .level(pgc_lvl_unused), .rise(pgc_rise), .fall(pgc_fall)
  );

  pic24icsp_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pgd (
    .clk(clk), .rstn(rstn), .d(PGD_in),
    .level(pgd_lvl), .rise(pgd_rise_unused), .fall(pgd_fall_unused)
  );

  pic24icsp_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mclr (
    .clk(clk), .rstn(rstn), .d(MCLRn),
    .level(mclr_lvl), .rise(mclr_rise), .fall(mclr_fall_unused)
  );

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [SIX_BITS-1:0]  rx_q, rx_d;
  logic [VISI_BITS-1:0] tx_q, tx_d;
  logic [SIX_BITS-1:0]  instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 pgd_out_q, pgd_out_d;
  logic                 pgd_oe_q, pgd_oe_d;
  logic [CMD_BITS-1:0]  cmd_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    cmd_err_d = 1'b0;
    pgd_out_d = pgd_out_q;
    pgd_oe_d  = pgd_oe_q;
    cmd_word  = '0;

    if (valid_q && cons.instr_ready) valid_d = 1'b0;

    if (!mclr_lvl) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      pgd_oe_d = 1'b0;
    end else begin
      // Bits shift in from the MSB end so LSB-first data lands in place.
      if (pgc_fall) rx_d = {pgd_lvl, rx_q[SIX_BITS-1:1]};
      cmd_word = rx_d[SIX_BITS-1 -: CMD_BITS];

      unique case (state_q)
        ST_IDLE: begin
          if (mclr_rise) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (pgc_fall) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == CMD_LAST) begin
              cnt_d = '0;
              if (cmd_word == CMD_SIX) begin
                state_d = ST_SIX_DATA;
              end else if (cmd_word == CMD_REGOUT) begin
                state_d = ST_REG_PAD;
                tx_d    = visi;
              end else begin
                state_d   = ST_SKIP;
                cmd_err_d = 1'b1;
              end
            end
          end
        end
        ST_SIX_DATA: begin
          if (pgc_fall) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == SIX_LAST) begin
              state_d = ST_CMD;
              cnt_d   = '0;
              instr_d = rx_d;
              valid_d = 1'b1;
              // A same-cycle consume frees the slot, so only a held word overruns.
              if (valid_q && !cons.instr_ready) overrun_d = 1'b1;
            end
          end
        end
        ST_SKIP: begin
          if (pgc_fall) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == SIX_LAST) begin
              state_d = ST_CMD;
              cnt_d   = '0;
            end
          end
        end
        ST_REG_PAD: begin
          if (pgc_fall) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == PAD_LAST) begin
              state_d = ST_REG_DATA;
              cnt_d   = '0;
            end
          end
        end
        ST_REG_DATA: begin
          if (pgc_rise) begin
            pgd_out_d = tx_q[0];
            tx_d      = tx_q >> 1;
            pgd_oe_d  = 1'b1;
          end
          if (pgc_fall) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == VISI_LAST) begin
              state_d  = ST_CMD;
              cnt_d    = '0;
              pgd_oe_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cmd_err_q <= 1'b0;
      pgd_out_q <= 1'b0;
      pgd_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cmd_err_q <= cmd_err_d;
      pgd_out_q <= pgd_out_d;
      pgd_oe_q  <= pgd_oe_d;
    end
  end

  assign PGD_out          = pgd_out_q;
  assign PGD_oe           = pgd_oe_q;
  assign cons.instr       = instr_q;
  assign cons.instr_valid = valid_q;
  assign cons.overrun     = overrun_q;
  assign cons.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_pic24icsp_target.sv
// Directed bench for pic24icsp_target: host-side ICSP bit-banging with
// hand-computed expected words, pulse counts and VISI readback.
module tb_pic24icsp_target;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        PGC = 1'b0;
  logic        PGD_in = 1'b0;
  logic        PGD_out;
  logic        PGD_oe;
  logic        MCLRn = 1'b0;
  logic [15:0] visi = '0;

  pic24icsp_if bus ();

  pic24icsp_target #(.SYNC_STAGES(2), .PAD_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .PGC(PGC), .PGD_in(PGD_in),
    .PGD_out(PGD_out), .PGD_oe(PGD_oe), .MCLRn(MCLRn),
    .visi(visi), .cons(bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cycles = 0;
  int cmd_err_cnt  = 0;
  int oe_cycles    = 0;

  always @(negedge clk) begin
    if (bus.instr_valid) valid_cycles++;
    if (bus.cmd_err)     cmd_err_cnt++;
    if (PGD_oe)          oe_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic pgc_bit(input logic b);
    PGD_in = b;
    PGC = 1'b1;
    repeat (HALF) @(negedge clk);
    PGC = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) pgc_bit(v[i]);
  endtask

  task automatic six(input logic [23:0] w);
    send(24'h0, 4);
    send(w, 24);
    repeat (4) @(negedge clk);
  endtask

  logic [15:0] rd;
  logic        oe_ok;

  initial begin
    bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_oe", PGD_oe, 0);
    check("rst_out", PGD_out, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_cmd_err", bus.cmd_err, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    MCLRn = 1'b1;
    repeat (10) @(negedge clk);

    // SIX with ready high
    valid_cycles = 0;
    six(24'h040200);
    check("six_instr", bus.instr, 24'h040200);
    check("six_valid_cycles", valid_cycles, 1);
    check("six_overrun", bus.overrun, 0);

    // REGOUT readback
    visi = 16'hA5C3;
    oe_cycles = 0;
    send(24'h1, 4);
    check("regout_oe_cmd", oe_cycles, 0);
    send(24'h0, 8);
    check("regout_oe_pad", oe_cycles, 0);
    rd = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      PGC = 1'b1;
      repeat (HALF - 1) @(negedge clk);
      rd[i] = PGD_out;
      if (PGD_oe !== 1'b1) oe_ok = 1'b0;
      @(negedge clk);
      PGC = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("regout_data", rd, 16'hA5C3);
    check("regout_oe_data", oe_ok, 1);
    check("regout_oe_after", PGD_oe, 0);
    check("regout_oe_cycles", oe_cycles, 248);

    // Back-pressure and overrun
    bus.instr_ready = 1'b0;
    six(24'h000000);
    check("bp_first_valid", bus.instr_valid, 1);
    check("bp_first_overrun", bus.overrun, 0);
    six(24'hBA0BB6);
    check("bp_instr", bus.instr, 24'hBA0BB6);
    check("bp_overrun", bus.overrun, 1);
    bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_valid_cleared", bus.instr_valid, 0);
    check("bp_overrun_sticky", bus.overrun, 1);

    // Invalid command is skipped
    cmd_err_cnt = 0;
    valid_cycles = 0;
    send(24'h5, 4);
    send(24'hFFFFFF, 24);
    repeat (4) @(negedge clk);
    check("inv_cmd_err", cmd_err_cnt, 1);
    check("inv_instr_kept", bus.instr, 24'hBA0BB6);
    check("inv_no_valid", valid_cycles, 0);
    six(24'h880190);
    check("inv_next_instr", bus.instr, 24'h880190);
    check("inv_next_valid", valid_cycles, 1);
    check("inv_err_total", cmd_err_cnt, 1);

    // MCLRn abort mid-word
    valid_cycles = 0;
    send(24'h0, 4);
    send(24'h123456, 10);
    MCLRn = 1'b0;
    repeat (10) @(negedge clk);
    MCLRn = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_valid", valid_cycles, 0);
    check("abort_instr_kept", bus.instr, 24'h880190);
    check("abort_overrun_kept", bus.overrun, 1);
    six(24'h207846);
    check("abort_instr", bus.instr, 24'h207846);
    check("abort_valid", valid_cycles, 1);

    // Reset during REG_DATA
    visi = 16'h1234;
    send(24'h1, 4);
    send(24'h0, 8);
    send(24'h0, 3);
    PGC = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    check("rd_oe_before_rst", PGD_oe, 1);
    rstn = 1'b0;
    #1;
    check("rd_rst_oe", PGD_oe, 0);
    check("rd_rst_out", PGD_out, 0);
    check("rd_rst_instr", bus.instr, 0);
    check("rd_rst_valid", bus.instr_valid, 0);
    check("rd_rst_overrun", bus.overrun, 0);
    check("rd_rst_cmd_err", bus.cmd_err, 0);
    PGC = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    valid_cycles = 0;
    six(24'h5A5A5A);
    check("post_rst_instr", bus.instr, 24'h5A5A5A);
    check("post_rst_valid", valid_cycles, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
